// File: rtl/cpu_axi_bridge.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cpu_axi_bridge
//
// Bridges the core's two SRAM-like ports (instruction fetch and data
// load/store) onto a single AXI3 master. The AR/R channels are shared, and
// data reads win over instruction reads. The AW/W/B channels serve only the
// data port. Each SRAM port has at most one transaction in flight.
//
// Optional build macro: BRIDGE_RESP_CHECK_EN
//   When it is defined, the bridge adds a sticky bus_err output. It is set by
//   any non-OKAY rresp or bresp and by any R beat whose rid matches no
//   outstanding request. Only reset clears it.
//
// Ports
//   clk, resetn          clock and synchronous active-low reset
//   inst_sram_*          fetch port. Its wr, wstrb and wdata inputs are ignored.
//   data_sram_*          load/store port
//   ar* / r*             AXI read address and read data channels
//   aw* / w* / b*        AXI write address, write data and write response channels
//   bus_err              sticky response error (BRIDGE_RESP_CHECK_EN only)
// ---------------------------------------------------------------------------
module cpu_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

`ifdef BRIDGE_RESP_CHECK_EN
    output logic        bus_err,
`endif

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic {R_IDLE, R_REQ} r_state_e;
    typedef enum logic [2:0] {W_IDLE, W_AW_W, W_AW, W_W, W_B} w_state_e;

    r_state_e    r_state_q, r_state_d;
    w_state_e    w_state_q, w_state_d;

    logic        inst_busy_q, inst_busy_d;
    logic        data_busy_q, data_busy_d;

    logic [31:0] araddr_q;
    logic [2:0]  arsize_q;
    logic [3:0]  arid_q;
    logic [31:0] awaddr_q;
    logic [2:0]  awsize_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        grant_data, grant_inst, w_accept, raw_block;
    logic        r_inst_hit, r_data_hit, b_done;

    // Inputs the bridge never looks at. They are collected here so that the
    // omission is visibly deliberate.
    logic        unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                             rlast, rresp, bid, bresp};

    // ---------------- fixed AXI fields ----------------
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign rready  = 1'b1;
    assign bready  = 1'b1;
    assign wlast   = 1'b1;
    assign awid    = DATA_ID;
    assign wid     = DATA_ID;

    // ---------------- request acceptance ----------------
    // A fetch from a word that still has a write in flight must wait until
    // that write has been acknowledged. Otherwise the fetch could return the
    // stale value.
    assign raw_block = (w_state_q != W_IDLE) &&
                       (inst_sram_addr[31:2] == awaddr_q[31:2]);

    // The grants are gated with resetn so that no addr_ok can leak out while
    // reset is held.
    assign grant_data = resetn && (r_state_q == R_IDLE) && data_sram_req &&
                        !data_sram_wr && !data_busy_q;
    assign grant_inst = resetn && (r_state_q == R_IDLE) && !grant_data &&
                        inst_sram_req && !inst_busy_q && !raw_block;
    assign w_accept   = resetn && (w_state_q == W_IDLE) && data_sram_req &&
                        data_sram_wr && !data_busy_q;

    assign inst_sram_addr_ok = grant_inst;
    assign data_sram_addr_ok = grant_data || w_accept;

    // ---------------- response routing ----------------
    assign r_inst_hit = rvalid && (rid == INST_ID) && inst_busy_q;
    assign r_data_hit = rvalid && (rid == DATA_ID) && data_busy_q;
    assign b_done     = (w_state_q == W_B) && bvalid;

    assign inst_sram_data_ok = r_inst_hit;
    assign inst_sram_rdata   = rdata;
    assign data_sram_data_ok = r_data_hit || b_done;
    assign data_sram_rdata   = rdata;

    // ---------------- busy flags ----------------
    always_comb begin
        inst_busy_d = inst_busy_q;
        data_busy_d = data_busy_q;
        if (grant_inst)
            inst_busy_d = 1'b1;
        else if (inst_sram_data_ok)
            inst_busy_d = 1'b0;
        if (grant_data || w_accept)
            data_busy_d = 1'b1;
        else if (data_sram_data_ok)
            data_busy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            inst_busy_q <= 1'b0;
            data_busy_q <= 1'b0;
        end else begin
            inst_busy_q <= inst_busy_d;
            data_busy_q <= data_busy_d;
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk) begin
        if (!resetn)
            r_state_q <= R_IDLE;
        else
            r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (grant_data || grant_inst) r_state_d = R_REQ;
            R_REQ:   if (arready)                  r_state_d = R_IDLE;
            default:                               r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arvalid = (r_state_q == R_REQ);
        araddr  = araddr_q;
        arsize  = arsize_q;
        arid    = arid_q;
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk) begin
        if (!resetn)
            w_state_q <= W_IDLE;
        else
            w_state_q <= w_state_d;
    end

    // AW and W complete independently. The FSM remembers which of the two
    // is still outstanding.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE: if (w_accept) w_state_d = W_AW_W;
            W_AW_W: begin
                if (awready && wready)
                    w_state_d = W_B;
                else if (awready)
                    w_state_d = W_W;
                else if (wready)
                    w_state_d = W_AW;
            end
            W_AW:    if (awready) w_state_d = W_B;
            W_W:     if (wready)  w_state_d = W_B;
            W_B:     if (bvalid)  w_state_d = W_IDLE;
            default:              w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awvalid = (w_state_q == W_AW_W) || (w_state_q == W_AW);
        wvalid  = (w_state_q == W_AW_W) || (w_state_q == W_W);
        awaddr  = awaddr_q;
        awsize  = awsize_q;
        wdata   = wdata_q;
        wstrb   = wstrb_q;
    end

    // ---------------- request field capture (no reset needed) ----------------
    always_ff @(posedge clk) begin
        if (grant_data) begin
            araddr_q <= data_sram_addr;
            arsize_q <= {1'b0, data_sram_size};
            arid_q   <= DATA_ID;
        end else if (grant_inst) begin
            araddr_q <= inst_sram_addr;
            arsize_q <= {1'b0, inst_sram_size};
            arid_q   <= INST_ID;
        end
        if (w_accept) begin
            awaddr_q <= data_sram_addr;
            awsize_q <= {1'b0, data_sram_size};
            wdata_q  <= data_sram_wdata;
            wstrb_q  <= data_sram_wstrb;
        end
    end

`ifdef BRIDGE_RESP_CHECK_EN
    // ---------------- sticky response error ----------------
    logic bus_err_q;

    always_ff @(posedge clk) begin
        if (!resetn)
            bus_err_q <= 1'b0;
        else if ((rvalid && ((rresp != 2'b00) || !(r_inst_hit || r_data_hit))) ||
                 (bvalid && (bresp != 2'b00)))
            bus_err_q <= 1'b1;
    end

    assign bus_err = bus_err_q;
`endif

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
Converts the core's two SRAM-like ports (instruction fetch, data load/store) onto one AXI3 master port. The read channel is shared: data reads have priority over instruction reads. The write channel serves the data port only. Sits between the core and the top-level AXI pins.

Parameters:
INST_ID, 4'd0, arid/rid tag for instruction reads
DATA_ID, 4'd1, arid/rid/awid/wid tag for data accesses

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
inst_sram_req/addr/size  input  1/32/2  fetch request; wr/wstrb/wdata inputs present but ignored
inst_sram_addr_ok/data_ok  output  1/1  request accepted / fetch data valid
inst_sram_rdata  output  32  fetched word
data_sram_req/wr/size/wstrb/addr/wdata  input  1/1/2/4/32/32  data request
data_sram_addr_ok/data_ok  output  1/1  request accepted / load data valid or store complete
data_sram_rdata  output  32  load word
arid/araddr/arsize/arvalid  output  4/32/3/1  AXI read address
arready  input  1  AXI read address ready
rid/rdata/rresp/rlast/rvalid  input  4/32/2/1/1  AXI read data
rready  output  1  constant 1
awid/awaddr/awsize/awvalid  output  4/32/3/1  AXI write address
awready  input  1  AXI write address ready
wid/wdata/wstrb/wlast/wvalid  output  4/32/4/1/1  AXI write data; wlast constant 1
wready  input  1
bid/bresp/bvalid  input  4/2/1
bready  output  1  constant 1
arlen/awlen, arburst/awburst, arlock/awlock, arcache/awcache, arprot/awprot  output  8/2/2/4/3  constants 0, 2'b01, 0, 0, 0

Behaviour:
- Reset: arvalid, awvalid, wvalid, all addr_ok/data_ok = 0; inst_busy = data_busy = 0; both FSMs idle. Reset mid-transaction abandons it with no AXI completion wait.
- Each port has at most one outstanding transaction (busy flag). A flag sets on accept and clears at the edge after its data_ok. A new accept on the same port is therefore possible no earlier than the cycle after data_ok.
- Read FSM: R_IDLE -> R_REQ.
  - In R_IDLE, grant data if data_req & ~data_wr & ~data_busy.
  - Otherwise grant inst if inst_req & ~inst_busy & ~raw_block.
  - Grant asserts that port's addr_ok combinationally. araddr, arsize = {1'b0,size} and arid are latched; next state is R_REQ.
  - R_REQ drives arvalid = 1 with stable fields until arready, then returns to R_IDLE. The next grant is possible in the cycle after the handshake.
- Write FSM: W_IDLE -> W_AW_W -> (W_AW | W_W) -> W_B.
  - Accept in W_IDLE when data_req & data_wr & ~data_busy; data_addr_ok = 1. awaddr/awsize/wdata/wstrb are latched.
  - W_AW_W drives awvalid and wvalid together. Each channel drops independently on its own ready. When both handshakes are done (same or different cycles), go to W_B.
  - W_B waits for bvalid, which gives data_data_ok = 1 for one cycle, then W_IDLE.
  - A read grant and a write accept cannot coincide, because both require ~data_busy and a request is either a read or a write.
- raw_block: 1 while the write FSM is not idle and inst_addr[31:2] == pending awaddr[31:2]. It blocks inst grant until the bvalid cycle completes.
- R channel (combinational passthrough, zero added latency):
  - rvalid & rid==INST_ID & inst_busy gives inst_data_ok = 1 and inst_rdata = rdata.
  - rvalid & rid==DATA_ID & data_busy gives data_data_ok = 1 and data_rdata = rdata.
  - rvalid with an unmatched rid is dropped.
- rvalid (data read) and bvalid cannot both target the data port in one cycle; the single-outstanding rule guarantees this.
- rresp/bresp ignored unless the optional feature is enabled.

Optional Feature:
BRIDGE_RESP_CHECK_EN.
- Defined: adds output bus_err (1 bit, reset 0). It becomes sticky 1 on any rvalid with rresp != 0, any bvalid with bresp != 0, or rvalid with an unmatched rid. It is cleared only by reset.
- Undefined: no bus_err port; responses are unchecked.

Test Plan:
- inst_req=1, addr=0x1c000000, data idle -> inst_addr_ok same cycle; next cycle arvalid=1, arid=0, araddr=0x1c000000, arsize=2. Then rvalid, rid=0, rdata=0x02800c0c -> inst_data_ok=1, inst_rdata=0x02800c0c.
- inst_req and data read (addr 0x1c001000) both asserted in R_IDLE -> only data_addr_ok=1, arid=1. Inst is granted the cycle after arready.
- Data store addr 0x1c002004, wstrb=4'b0011, wdata=0x1234abcd; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles. bvalid -> data_data_ok=1.
- Pending store to 0x1c003008; inst_req to 0x1c00300a -> no inst_addr_ok until the bvalid cycle completes. Inst_req to 0x1c00300c -> granted immediately.
- Reset asserted while arvalid=1 and awvalid=1 -> next cycle all valids 0, busy flags 0, FSMs idle.
- BRIDGE_RESP_CHECK_EN: bvalid with bresp=2'b10 -> bus_err=1 next cycle, and it stays 1 through later OKAY responses.
